// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder: default word shape, SPI mode,
// one-hot state encoding and a small edge-select helper.
package spi_slave_pkg;

    localparam int   DATA_WIDTH_DEF = 8;
    localparam logic CPOL_DEF       = 1'b0;
    localparam logic CPHA_DEF       = 1'b0;

    // One-hot frame states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_SHIFT = 3'b010,
        ST_DONE  = 3'b100
    } state_e;

    // Pick between two edge strobes according to a mode bit
    function automatic logic pick_edge(input logic sel, input logic when_set, input logic when_clr);
        return sel ? when_set : when_clr;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by one delay flop; exposes the synchronized
// level and single-cycle rise/fall strobes. Reset level is a parameter so that
// each pin starts at its idle value and no spurious edge appears after reset.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q, dly_d;

    // Next values of the synchronizer chain
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Synchronizer and edge-detect delay registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            dly_q  <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~dly_q;
    assign fall_o  = ~sync_q & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples the SPI pins on clk, shifts mosi into rx_data LSB
// first and drives miso from tx_data. One word per DATA_WIDTH sample edges
// while ss_n is low; back-to-back words reload tx_data through a one-cycle DONE.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int   DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic CPOL       = CPOL_DEF,
    parameter logic CPHA       = CPHA_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_load,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  abort
);

    localparam int            IW        = $clog2(DATA_WIDTH);
    localparam int            CW        = IW + 1;
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_WORD  = CW'(DATA_WIDTH);

    logic sclk_lvl_unused_s, sclk_rise_s, sclk_fall_s;
    logic ss_lvl_s, ss_rise_s, ss_fall_s;
    logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;
    logic lead_s, trail_s, sample_s, launch_s;

    state_e                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  miso_q, miso_d;
    logic                  tx_load_q, tx_load_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;
    logic                  abort_q, abort_d;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .async_i(sclk),
        .level_o(sclk_lvl_unused_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst_n(rst_n), .async_i(ss_n),
        .level_o(ss_lvl_s), .rise_o(ss_rise_s), .fall_o(ss_fall_s)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .async_i(mosi),
        .level_o(mosi_s), .rise_o(mosi_rise_unused_s), .fall_o(mosi_fall_unused_s)
    );

    // Map raw sclk edges onto the mode's leading/trailing and sample/launch roles
    always_comb begin
        lead_s   = pick_edge(CPOL, sclk_fall_s, sclk_rise_s);
        trail_s  = pick_edge(CPOL, sclk_rise_s, sclk_fall_s);
        sample_s = pick_edge(CPHA, trail_s, lead_s);
        launch_s = pick_edge(CPHA, lead_s, trail_s);
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next frame state; ss_n rise wins over any simultaneous sample edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall_s) state_d = ST_SHIFT;
                else           state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (ss_rise_s)                               state_d = ST_IDLE;
                else if (sample_s && (bit_cnt_q == CNT_LAST)) state_d = ST_DONE;
                else                                         state_d = ST_SHIFT;
            end
            ST_DONE: begin
                if (ss_rise_s) state_d = ST_IDLE;
                else           state_d = ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift registers, bit counter and registered outputs per state
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        miso_d     = miso_q;
        tx_load_d  = 1'b0;
        rx_valid_d = 1'b0;
        abort_d    = 1'b0;
        busy_d     = ~ss_lvl_s;
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ss_fall_s) begin
                    tx_shift_d = tx_data;
                    tx_load_d  = 1'b1;
                    bit_cnt_d  = CNT_ZERO;
                    miso_d     = CPHA ? 1'b0 : tx_data[0];
                end else begin
                    bit_cnt_d  = CNT_ZERO;
                end
            end
            ST_SHIFT: begin
                if (ss_rise_s) begin
                    // A partial word is dropped; only report it if bits arrived
                    abort_d   = (bit_cnt_q != CNT_ZERO);
                    bit_cnt_d = CNT_ZERO;
                    miso_d    = 1'b0;
                end else if (sample_s) begin
                    rx_shift_d = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d  = bit_cnt_q + CNT_ONE;
                end else if (launch_s && (CPHA || (bit_cnt_q < CNT_WORD))) begin
                    // With CPHA=0 and bit_cnt=0 this re-drives bit 0, so the
                    // trailing edge after a load never skips ahead
                    miso_d = tx_shift_q[bit_cnt_q[IW-1:0]];
                end else begin
                    miso_d = miso_q;
                end
            end
            ST_DONE: begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                tx_shift_d = tx_data;
                tx_load_d  = 1'b1;
                bit_cnt_d  = CNT_ZERO;
                if (!CPHA) miso_d = tx_data[0];
                else       miso_d = miso_q;
            end
            default: begin
                bit_cnt_d = CNT_ZERO;
                miso_d    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= CNT_ZERO;
            tx_shift_q <= {DATA_WIDTH{1'b0}};
            rx_shift_q <= {DATA_WIDTH{1'b0}};
            rx_data_q  <= {DATA_WIDTH{1'b0}};
            miso_q     <= 1'b0;
            tx_load_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            miso_q     <= miso_d;
            tx_load_q  <= tx_load_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            abort_q    <= abort_d;
        end
    end

    assign miso     = miso_q;
    assign tx_load  = tx_load_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign abort    = abort_q;

endmodule
